// File: rtl/vr_prep_pkg.sv
// Shared types for the VR PREPARE engine controller.
package vr_prep_pkg;

    // Width of the optional statistics counters.
    localparam int STAT_W = 32;

    typedef enum logic [2:0] {
        READY,
        HANDLE_OP,
        WAIT_SPACE,
        SEND_META,
        SEND_DATA
    } prep_state_e;

endpackage

// File: rtl/vr_outstanding_cnt.sv
// Up/down saturating counter of in-flight log writes.
// Also provides full/empty flags and a sticky underflow flag.
module vr_outstanding_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full_o,
    output logic empty_o,
    output logic underflow_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q, count_d;
    logic         err_q, err_d;

    // Next count: simultaneous inc/dec cancel; a dec at zero only flags the error.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (inc && !dec) begin
            if (count_q != MAX_V) count_d = count_q + 1'b1;
        end else if (dec && !inc) begin
            if (count_q == '0) err_d   = 1'b1;
            else               count_d = count_q - 1'b1;
        end
    end

    // Count and sticky error registers; the error clears only on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign full_o      = (count_q == MAX_V);
    assign empty_o     = (count_q == '0);
    assign underflow_o = err_q;

endmodule

// File: rtl/vr_prep_eng_ctrl_pipe.sv
// Control FSM for the VR replica PREPARE engine, pipelined version.
// Accepts a PREPARE, decides accept/stall/drop, starts log ingest and
// emits a PREPARE_OK, with up to MAX_OUTSTANDING log writes in flight.
// Define VR_PREP_STATS_EN to add accepted/dropped/stall-cycle counters.
module vr_prep_eng_ctrl_pipe
    import vr_prep_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int PREP_OK_BEATS   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               manage_prep_msg_val,
    output logic                               prep_manage_msg_rdy,
    input  logic                               manage_prep_req_val,
    output logic                               ctrl_datap_store_info,
    input  logic                               datap_ctrl_prep_ok,
    input  logic                               datap_ctrl_log_has_space,
    output logic                               prep_vr_state_wr_req,
    output logic                               start_req_ingest,
    output logic                               ctrl_datap_drop_req,
    input  logic                               log_write_done,
    output logic                               prep_to_udp_meta_val,
    input  logic                               to_udp_prep_meta_rdy,
    output logic                               prep_to_udp_data_val,
    output logic                               prep_to_udp_data_last,
    input  logic                               to_udp_prep_data_rdy,
    output logic [$clog2(PREP_OK_BEATS):0]     prep_beat_idx,
    output logic                               prep_engine_rdy,
    output logic                               prep_engine_idle,
    output logic                               err_done_underflow
`ifdef VR_PREP_STATS_EN
    ,
    output logic [STAT_W-1:0]                  stat_prep_accepted,
    output logic [STAT_W-1:0]                  stat_prep_dropped,
    output logic [STAT_W-1:0]                  stat_stall_cycles
`endif
);

    localparam int                 OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int                 BEAT_W    = $clog2(PREP_OK_BEATS) + 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(PREP_OK_BEATS - 1);

    prep_state_e       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              accept;
    logic              can_take;
    logic              cnt_full;
    logic              cnt_empty;

    // Full check uses the registered count, so a completion landing while
    // full only unblocks the following cycle.
    assign can_take = datap_ctrl_log_has_space && !cnt_full;

    vr_outstanding_cnt #(
        .MAX (MAX_OUTSTANDING),
        .W   (OUT_W)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc         (accept),
        .dec         (log_write_done),
        .full_o      (cnt_full),
        .empty_o     (cnt_empty),
        .underflow_o (err_done_underflow)
    );

    // Next-state and output decode.
    always_comb begin
        state_d               = state_q;
        beat_d                = beat_q;
        accept                = 1'b0;
        prep_manage_msg_rdy   = 1'b0;
        ctrl_datap_store_info = 1'b0;
        prep_engine_rdy       = 1'b0;
        ctrl_datap_drop_req   = 1'b0;
        prep_to_udp_meta_val  = 1'b0;
        prep_to_udp_data_val  = 1'b0;
        prep_to_udp_data_last = 1'b0;
        case (state_q)
            READY: begin
                ctrl_datap_store_info = 1'b1;
                prep_engine_rdy       = 1'b1;
                if (manage_prep_msg_val && manage_prep_req_val) begin
                    prep_manage_msg_rdy = 1'b1;
                    state_d             = HANDLE_OP;
                end
            end
            HANDLE_OP: begin
                if (!datap_ctrl_prep_ok) begin
                    ctrl_datap_drop_req = 1'b1;
                    state_d             = READY;
                end else if (can_take) begin
                    accept  = 1'b1;
                    state_d = SEND_META;
                end else begin
                    state_d = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (can_take) begin
                    accept  = 1'b1;
                    state_d = SEND_META;
                end
            end
            SEND_META: begin
                prep_to_udp_meta_val = 1'b1;
                if (to_udp_prep_meta_rdy) begin
                    beat_d  = '0;
                    state_d = SEND_DATA;
                end
            end
            SEND_DATA: begin
                prep_to_udp_data_val  = 1'b1;
                prep_to_udp_data_last = (beat_q == LAST_BEAT);
                if (to_udp_prep_data_rdy) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = READY;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = READY;
        endcase
    end

    // State and beat registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= READY;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    assign prep_vr_state_wr_req = accept;
    assign start_req_ingest     = accept;
    assign prep_beat_idx        = beat_q;
    assign prep_engine_idle     = prep_engine_rdy && cnt_empty;

`ifdef VR_PREP_STATS_EN
    logic [STAT_W-1:0] acc_q, acc_d, drop_q, drop_d, stall_q, stall_d;

    // Wrapping event counters.
    always_comb begin
        acc_d   = acc_q + STAT_W'(accept);
        drop_d  = drop_q + STAT_W'(ctrl_datap_drop_req);
        stall_d = stall_q + STAT_W'(state_q == WAIT_SPACE);
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            drop_q  <= '0;
            stall_q <= '0;
        end else begin
            acc_q   <= acc_d;
            drop_q  <= drop_d;
            stall_q <= stall_d;
        end
    end

    assign stat_prep_accepted = acc_q;
    assign stat_prep_dropped  = drop_q;
    assign stat_stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_vr_prep_eng_ctrl_pipe.sv
// Bench for vr_prep_eng_ctrl_pipe: directed stimulus, expected data beats
// queued at issue time and consumed by an independent output monitor.
module tb_vr_prep_eng_ctrl_pipe;

    localparam int MAXO  = 4;
    localparam int BEATS = 3;
    localparam int BW    = $clog2(BEATS) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic msg_val = 0, req_val = 0, prep_ok = 0, log_space = 0, done = 0;
    logic meta_rdy = 0, data_rdy = 0;
    logic msg_rdy, store_info, wr_req, ingest, drop_req;
    logic meta_val, data_val, data_last, eng_rdy, eng_idle, err;
    logic [BW-1:0] beat_idx;

    typedef struct packed {
        logic [BW-1:0] idx;
        logic          last;
    } beat_t;
    beat_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vr_prep_eng_ctrl_pipe #(.MAX_OUTSTANDING(MAXO), .PREP_OK_BEATS(BEATS)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .manage_prep_msg_val      (msg_val),
        .prep_manage_msg_rdy      (msg_rdy),
        .manage_prep_req_val      (req_val),
        .ctrl_datap_store_info    (store_info),
        .datap_ctrl_prep_ok       (prep_ok),
        .datap_ctrl_log_has_space (log_space),
        .prep_vr_state_wr_req     (wr_req),
        .start_req_ingest         (ingest),
        .ctrl_datap_drop_req      (drop_req),
        .log_write_done           (done),
        .prep_to_udp_meta_val     (meta_val),
        .to_udp_prep_meta_rdy     (meta_rdy),
        .prep_to_udp_data_val     (data_val),
        .prep_to_udp_data_last    (data_last),
        .to_udp_prep_data_rdy     (data_rdy),
        .prep_beat_idx            (beat_idx),
        .prep_engine_rdy          (eng_rdy),
        .prep_engine_idle         (eng_idle),
        .err_done_underflow       (err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pop on each data handshake, plus hold rules.
    logic          p_dv = 0, p_dr = 0, p_mv = 0, p_mr = 0;
    logic [BW-1:0] p_idx = '0;
    always @(negedge clk) begin
        if (rst) begin
            p_dv = 0; p_dr = 0; p_mv = 0; p_mr = 0; p_idx = '0;
        end else begin
            if (data_val && data_rdy) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_beat", 32'(beat_idx), 32'hFFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("sb_beat_idx", 32'(beat_idx), 32'(e.idx));
                    check("sb_data_last", 32'(data_last), 32'(e.last));
                end
            end
            if (p_dv && !p_dr) check("data_hold", {data_val, 8'(beat_idx)}, {1'b1, 8'(p_idx)});
            if (p_mv && !p_mr) check("meta_hold", 32'(meta_val), 32'd1);
            p_dv = data_val; p_dr = data_rdy; p_mv = meta_val; p_mr = meta_rdy; p_idx = beat_idx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt();
        for (int i = 0; i < BEATS; i++) begin
            beat_t e;
            e.idx  = BW'(i);
            e.last = (i == BEATS - 1);
            exp_q.push_back(e);
        end
    endtask

    // Issue an accepted PREPARE and run it through SEND_META.
    task automatic start_prep(input int meta_stall, input logic done_w_ingest);
        msg_val = 1; req_val = 1; prep_ok = 1; log_space = 1;
        @(negedge clk);
        check("msg_rdy", 32'(msg_rdy), 32'd1);
        check("store_info", 32'(store_info), 32'd1);
        check("eng_rdy_ready", 32'(eng_rdy), 32'd1);
        push_pkt();
        tick();
        msg_val = 0; req_val = 0; done = done_w_ingest;
        @(negedge clk);
        check("wr_req", 32'(wr_req), 32'd1);
        check("ingest", 32'(ingest), 32'd1);
        check("meta_early", 32'(meta_val), 32'd0);
        tick();
        done = 0; meta_rdy = 0;
        for (int i = 0; i < meta_stall; i++) begin
            @(negedge clk);
            check("meta_stall_val", 32'(meta_val), 32'd1);
            tick();
        end
        meta_rdy = 1;
        @(negedge clk);
        check("meta_val_cyc2", 32'(meta_val), 32'd1);
        tick();
        meta_rdy = 0;
    endtask

    task automatic data_all();
        data_rdy = 1;
        for (int i = 0; i < BEATS; i++) begin
            @(negedge clk);
            check("data_val", 32'(data_val), 32'd1);
            tick();
        end
        data_rdy = 0;
        @(negedge clk);
        check("back_ready", 32'(eng_rdy), 32'd1);
        check("data_val_off", 32'(data_val), 32'd0);
        tick();
    endtask

    task automatic pulse_done();
        done = 1;
        tick();
        done = 0;
    endtask

    task automatic chk_cnt(input string nm, input int exp);
        @(negedge clk);
        check(nm, 32'(dut.u_cnt.count_q), 32'(exp));
        tick();
    endtask

    logic [BW-1:0] t2_idx  [5] = '{0, 1, 1, 2, 2};
    logic          t2_last [5] = '{0, 0, 0, 1, 1};
    logic          t2_rdy  [5] = '{1, 0, 1, 0, 1};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_msg_rdy", 32'(msg_rdy), 0);
        check("rst_meta_val", 32'(meta_val), 0);
        check("rst_data_val", 32'(data_val), 0);
        check("rst_strobes", {wr_req, ingest, drop_req}, 0);
        check("rst_err", 32'(err), 0);
        check("rst_idle", {eng_rdy, eng_idle, store_info}, 3'b111);
        @(posedge clk); #1 rst = 0;
        tick();

        // 1: basic accepted PREPARE
        start_prep(0, 0);
        data_all();
        @(negedge clk);
        check("t1_idle_busy", 32'(eng_idle), 0);
        tick();
        chk_cnt("t1_count", 1);
        pulse_done();
        chk_cnt("t1_count_drained", 0);

        // 2: data back-pressure pattern, with meta stalled too
        start_prep(2, 0);
        for (int i = 0; i < 5; i++) begin
            data_rdy = t2_rdy[i];
            @(negedge clk);
            check("t2_data_val", 32'(data_val), 1);
            check("t2_beat_idx", 32'(beat_idx), 32'(t2_idx[i]));
            check("t2_last", 32'(data_last), 32'(t2_last[i]));
            tick();
        end
        data_rdy = 0;
        @(negedge clk);
        check("t2_ready", 32'(eng_rdy), 1);
        tick();
        pulse_done();

        // 3: fill to MAX, fifth stalls until a completion
        for (int k = 0; k < MAXO; k++) begin
            start_prep(0, 0);
            data_all();
        end
        chk_cnt("t3_full", MAXO);
        msg_val = 1; req_val = 1;
        @(negedge clk);
        check("t3_msg_rdy", 32'(msg_rdy), 1);
        push_pkt();
        tick();
        msg_val = 0; req_val = 0;
        @(negedge clk);
        check("t3_no_ingest_handle", {wr_req, ingest}, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_wait", {meta_val, ingest, eng_rdy, eng_idle}, 0);
            tick();
        end
        done = 1;
        @(negedge clk);
        check("t3_full_boundary", {wr_req, ingest}, 0);
        tick();
        done = 0;
        @(negedge clk);
        check("t3_unblock", {wr_req, ingest, eng_idle}, 3'b110);
        tick();
        meta_rdy = 1;
        @(negedge clk);
        check("t3_meta", 32'(meta_val), 1);
        tick();
        meta_rdy = 0;
        data_all();
        chk_cnt("t3_count_after", MAXO);
        for (int k = 0; k < MAXO; k++) pulse_done();
        chk_cnt("t3_drained", 0);

        // 4: dropped PREPARE
        msg_val = 1; req_val = 1; prep_ok = 0;
        @(negedge clk);
        check("t4_msg_rdy", 32'(msg_rdy), 1);
        tick();
        msg_val = 0; req_val = 0;
        @(negedge clk);
        check("t4_drop", {drop_req, wr_req, ingest, meta_val}, 4'b1000);
        tick();
        @(negedge clk);
        check("t4_ready", {eng_rdy, eng_idle, drop_req}, 3'b110);
        check("t4_count", 32'(dut.u_cnt.count_q), 0);
        tick();

        // 5: simultaneous inc/dec, then underflow
        start_prep(0, 0); data_all();
        start_prep(0, 0); data_all();
        chk_cnt("t5_count2", 2);
        start_prep(0, 1); data_all();
        chk_cnt("t5_inc_dec_same", 2);
        pulse_done(); pulse_done();
        @(negedge clk);
        check("t5_err_before", 32'(err), 0);
        tick();
        pulse_done();
        @(negedge clk);
        check("t5_err_set", 32'(err), 1);
        check("t5_count_zero", 32'(dut.u_cnt.count_q), 0);
        tick();

        // 6: reset in the middle of SEND_DATA
        start_prep(0, 0);
        @(negedge clk);
        check("t6_in_data", 32'(data_val), 1);
        tick();
        #3 rst = 1;
        #1;
        check("t6_rst_outputs", {msg_rdy, wr_req, ingest, drop_req, meta_val, data_val, data_last, err}, 0);
        check("t6_rst_count", 32'(dut.u_cnt.count_q), 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("t6_after", {eng_rdy, eng_idle}, 2'b11);
        tick();
        start_prep(0, 0); data_all();
        chk_cnt("t6_post_count", 1);

        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
